// File: rtl/uart_tx_frame_gen_if.sv
// Parallel request side and serial/status side of the UART transmitter.
// The master drives the byte and frame options, and the slave (the transmitter) drives the line.
interface uart_tx_frame_gen_if #(
    parameter int DATA_WIDTH = 8
);
    logic [4:0]            Prescale_tx;
    logic [DATA_WIDTH-1:0] P_DATA_tx;
    logic                  Data_Valid_tx;
    logic                  PAR_EN_tx;
    logic                  PAR_TYP_tx;
    logic                  TX_OUT_tx;
    logic                  Busy_tx;

    modport master (
        output Prescale_tx, P_DATA_tx, Data_Valid_tx, PAR_EN_tx, PAR_TYP_tx,
        input  TX_OUT_tx, Busy_tx
    );

    modport slave (
        input  Prescale_tx, P_DATA_tx, Data_Valid_tx, PAR_EN_tx, PAR_TYP_tx,
        output TX_OUT_tx, Busy_tx
    );
endinterface

// File: rtl/uart_tx_frame_gen.sv
// UART transmitter. It sends start, data LSB-first, optional parity and stop.
// Every bit lasts exactly Prescale clocks, timed by an edge/bit counter pair that mirrors the RX side.
module uart_tx_frame_gen #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                 CLK_tx,
    input  logic                 RST_tx,
    uart_tx_frame_gen_if.slave   bus
);
    localparam int BIT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t                state, state_nxt;
    logic [4:0]            edge_cnt, edge_cnt_nxt;
    logic [BIT_W-1:0]      bit_cnt, bit_cnt_nxt;
    logic [DATA_WIDTH-1:0] data_q, data_nxt;
    logic                  par_en_q, par_en_nxt;
    logic                  par_typ_q, par_typ_nxt;
    logic [4:0]            prescale_q, prescale_nxt;
    logic                  tx_q, tx_nxt;
    logic                  busy_q, busy_nxt;

    logic [4:0]            last_edge;
    logic                  bit_end;
    logic                  parity_bit;
    logic [BIT_W-1:0]      bit_idx_nxt;

    // Only 8 is honoured as-is. Every other latched prescale runs at 16 clocks per bit.
    assign last_edge   = (prescale_q == 5'd8) ? 5'd7 : 5'd15;
    assign bit_end     = (edge_cnt == last_edge);
    assign parity_bit  = (^data_q) ^ par_typ_q;
    assign bit_idx_nxt = bit_cnt + 1'b1;

    // NOTE: every *_nxt gets its current value first, so no path can leave one unassigned and infer a latch.
    always_comb begin
        state_nxt    = state;
        edge_cnt_nxt = edge_cnt;
        bit_cnt_nxt  = bit_cnt;
        data_nxt     = data_q;
        par_en_nxt   = par_en_q;
        par_typ_nxt  = par_typ_q;
        prescale_nxt = prescale_q;
        tx_nxt       = tx_q;
        busy_nxt     = busy_q;

        if (state != IDLE)
            edge_cnt_nxt = bit_end ? 5'd0 : edge_cnt + 5'd1;

        case (state)
            IDLE: begin
                if (bus.Data_Valid_tx) begin
                    data_nxt     = bus.P_DATA_tx;
                    par_en_nxt   = bus.PAR_EN_tx;
                    par_typ_nxt  = bus.PAR_TYP_tx;
                    prescale_nxt = bus.Prescale_tx;
                    edge_cnt_nxt = 5'd0;
                    bit_cnt_nxt  = '0;
                    tx_nxt       = 1'b0;
                    busy_nxt     = 1'b1;
                    state_nxt    = START;
                end
            end
            START: begin
                if (bit_end) begin
                    state_nxt   = DATA;
                    bit_cnt_nxt = '0;
                    tx_nxt      = data_q[0];
                end
            end
            DATA: begin
                if (bit_end) begin
                    if (bit_cnt == LAST_BIT) begin
                        bit_cnt_nxt = '0;
                        state_nxt   = par_en_q ? PARITY : STOP;
                        tx_nxt      = par_en_q ? parity_bit : 1'b1;
                    end else begin
                        bit_cnt_nxt = bit_idx_nxt;
                        tx_nxt      = data_q[bit_idx_nxt];
                    end
                end
            end
            PARITY: begin
                if (bit_end) begin
                    state_nxt = STOP;
                    tx_nxt    = 1'b1;
                end
            end
            STOP: begin
                if (bit_end) begin
                    state_nxt = IDLE;
                    tx_nxt    = 1'b1;
                    busy_nxt  = 1'b0;
                end
            end
            default: begin
                state_nxt = IDLE;
                tx_nxt    = 1'b1;
                busy_nxt  = 1'b0;
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge CLK_tx) begin
        if (RST_tx) begin
            state      <= IDLE;
            edge_cnt   <= 5'd0;
            bit_cnt    <= '0;
            data_q     <= '0;
            par_en_q   <= 1'b0;
            par_typ_q  <= 1'b0;
            prescale_q <= 5'd0;
            tx_q       <= 1'b1;
            busy_q     <= 1'b0;
        end else begin
            state      <= state_nxt;
            edge_cnt   <= edge_cnt_nxt;
            bit_cnt    <= bit_cnt_nxt;
            data_q     <= data_nxt;
            par_en_q   <= par_en_nxt;
            par_typ_q  <= par_typ_nxt;
            prescale_q <= prescale_nxt;
            tx_q       <= tx_nxt;
            busy_q     <= busy_nxt;
        end
    end

    assign bus.TX_OUT_tx = tx_q;
    assign bus.Busy_tx   = busy_q;
endmodule

// File: tb/tb_uart_tx_frame_gen.sv
// Scoreboard bench for uart_tx_frame_gen. Each accepted request pushes its expected frame.
// The serial line is captured per cycle while Busy_tx is high and then scored against the popped entry.
module tb_uart_tx_frame_gen;
    localparam int DW = 8;

    typedef struct {
        logic [DW-1:0] data;
        logic          pe;
        logic          pt;
        int            p;
    } exp_t;

    logic CLK_tx = 1'b0;
    logic RST_tx = 1'b1;

    uart_tx_frame_gen_if #(.DATA_WIDTH(DW)) bus ();

    uart_tx_frame_gen #(.DATA_WIDTH(DW)) dut (
        .CLK_tx (CLK_tx),
        .RST_tx (RST_tx),
        .bus    (bus)
    );

    always #5 CLK_tx = ~CLK_tx;

    exp_t sb[$];
    logic cap[$];
    int   n_pass  = 0;
    int   n_total = 0;

    function automatic int eff_p(input logic [4:0] pre);
        return (pre == 5'd8) ? 8 : 16;
    endfunction

    function automatic int frame_len(input exp_t e);
        return (DW + 2 + (e.pe ? 1 : 0)) * e.p;
    endfunction

    // The bit that should be on the line in cycle i of a frame.
    function automatic logic exp_bit(input exp_t e, input int i);
        int b;
        b = i / e.p;
        if (b == 0) return 1'b0;
        if (b <= DW) return e.data[b-1];
        if (e.pe && b == DW + 1) return (^e.data) ^ e.pt;
        return 1'b1;
    endfunction

    function automatic int wave_errs(input exp_t e);
        int errs;
        errs = 0;
        for (int i = 0; i < cap.size(); i++)
            if (cap[i] !== exp_bit(e, i)) errs++;
        return errs;
    endfunction

    // Call at a negedge. The request is accepted at the next posedge, and the task returns at the negedge after that.
    task automatic strobe(input logic [DW-1:0] d, input logic pe, input logic pt, input logic [4:0] pre);
        bus.P_DATA_tx     = d;
        bus.PAR_EN_tx     = pe;
        bus.PAR_TYP_tx    = pt;
        bus.Prescale_tx   = pre;
        bus.Data_Valid_tx = 1'b1;
        sb.push_back('{data: d, pe: pe, pt: pt, p: eff_p(pre)});
        @(negedge CLK_tx);
        bus.Data_Valid_tx = 1'b0;
    endtask

    // Records TX_OUT_tx once per cycle while Busy_tx is high. The start wait and the frame are both bounded.
    task automatic capture(output bit started);
        started = 1'b0;
        cap.delete();
        for (int i = 0; i < 64; i++) begin
            if (bus.Busy_tx === 1'b1) begin
                started = 1'b1;
                break;
            end
            @(negedge CLK_tx);
        end
        for (int i = 0; i < 400 && started && bus.Busy_tx === 1'b1; i++) begin
            cap.push_back(bus.TX_OUT_tx);
            @(negedge CLK_tx);
        end
    endtask

    task automatic test_reset();
        int bad;
        bus.Prescale_tx = 5'd8; bus.P_DATA_tx = '0; bus.Data_Valid_tx = 1'b0;
        bus.PAR_EN_tx = 1'b0; bus.PAR_TYP_tx = 1'b0;
        repeat (3) @(negedge CLK_tx);
        n_total++;
        if ({bus.TX_OUT_tx, bus.Busy_tx} !== 2'b10)
            $display("FAIL reset_state tx/busy got %b%b want 10", bus.TX_OUT_tx, bus.Busy_tx);
        else n_pass++;
        RST_tx = 1'b0;
        bad = 0;
        repeat (20) begin
            @(negedge CLK_tx);
            if ({bus.TX_OUT_tx, bus.Busy_tx} !== 2'b10) bad++;
        end
        n_total++;
        if (bad !== 0) $display("FAIL idle_20 bad cycles got %0d want 0", bad);
        else n_pass++;
    endtask

    task automatic test_8n1();
        exp_t e; bit started; int errs; logic [7:0] rx;
        strobe(8'hA5, 1'b0, 1'b0, 5'd8);
        capture(started);
        e = sb.pop_front();
        n_total++;
        if (cap.size() !== 80) $display("FAIL 8n1_busy_cycles got %0d want 80", cap.size());
        else n_pass++;
        errs = wave_errs(e);
        n_total++;
        if (errs !== 0) $display("FAIL 8n1_wave bad cycles got %0d want 0", errs);
        else n_pass++;
        for (int k = 0; k < 8; k++) rx[k] = cap[8 * (k + 1) + 4];
        n_total++;
        if (rx !== 8'hA5) $display("FAIL 8n1_midbit_byte got %h want a5", rx);
        else n_pass++;
    endtask

    task automatic test_parity_and_ignore();
        exp_t e; bit started; int errs; int bad;
        // Even parity, with a second strobe carrying other data and prescale partway through the frame.
        fork
            capture(started);
            begin
                strobe(8'h07, 1'b1, 1'b0, 5'd16);
                repeat (30) @(negedge CLK_tx);
                bus.P_DATA_tx = 8'hFF; bus.Prescale_tx = 5'd8; bus.PAR_EN_tx = 1'b0;
                bus.Data_Valid_tx = 1'b1;
                @(negedge CLK_tx);
                bus.Data_Valid_tx = 1'b0;
            end
        join
        e = sb.pop_front();
        n_total++;
        if (cap.size() !== 176) $display("FAIL even_busy_cycles got %0d want 176", cap.size());
        else n_pass++;
        errs = wave_errs(e);
        n_total++;
        if (errs !== 0) $display("FAIL even_wave bad cycles got %0d want 0", errs);
        else n_pass++;
        n_total++;
        if (cap[16 * 9 + 8] !== 1'b1) $display("FAIL even_parity_bit got %b want 1", cap[16 * 9 + 8]);
        else n_pass++;
        bad = 0;
        repeat (40) begin
            @(negedge CLK_tx);
            if (bus.Busy_tx !== 1'b0) bad++;
        end
        n_total++;
        if (bad !== 0) $display("FAIL ignored_strobe_queued busy cycles got %0d want 0", bad);
        else n_pass++;

        strobe(8'h07, 1'b1, 1'b1, 5'd16);
        capture(started);
        e = sb.pop_front();
        n_total++;
        if (cap.size() !== 176) $display("FAIL odd_busy_cycles got %0d want 176", cap.size());
        else n_pass++;
        errs = wave_errs(e);
        n_total++;
        if (errs !== 0) $display("FAIL odd_wave bad cycles got %0d want 0", errs);
        else n_pass++;
        n_total++;
        if (cap[16 * 9 + 8] !== 1'b0) $display("FAIL odd_parity_bit got %b want 0", cap[16 * 9 + 8]);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        exp_t e; bit started; int errs; int gap; int idle_bad;
        bus.P_DATA_tx = 8'h3C; bus.PAR_EN_tx = 1'b0; bus.PAR_TYP_tx = 1'b0;
        bus.Prescale_tx = 5'd8; bus.Data_Valid_tx = 1'b1;
        sb.push_back('{data: 8'h3C, pe: 1'b0, pt: 1'b0, p: 8});
        sb.push_back('{data: 8'h3C, pe: 1'b0, pt: 1'b0, p: 8});
        @(negedge CLK_tx);
        capture(started);
        e = sb.pop_front();
        errs = wave_errs(e);
        n_total++;
        if (cap.size() !== frame_len(e) || errs !== 0)
            $display("FAIL b2b_frame1 len got %0d want %0d, bad cycles %0d", cap.size(), frame_len(e), errs);
        else n_pass++;
        gap = 0; idle_bad = 0;
        while (bus.Busy_tx !== 1'b1 && gap < 10) begin
            if (bus.TX_OUT_tx !== 1'b1) idle_bad++;
            gap++;
            @(negedge CLK_tx);
        end
        bus.Data_Valid_tx = 1'b0;
        n_total++;
        if (gap !== 1 || idle_bad !== 0)
            $display("FAIL b2b_gap idle cycles got %0d (low %0d) want 1 (low 0)", gap, idle_bad);
        else n_pass++;
        capture(started);
        e = sb.pop_front();
        errs = wave_errs(e);
        n_total++;
        if (cap.size() !== frame_len(e) || errs !== 0)
            $display("FAIL b2b_frame2 len got %0d want %0d, bad cycles %0d", cap.size(), frame_len(e), errs);
        else n_pass++;
    endtask

    task automatic test_reset_midframe();
        exp_t e; bit started; int errs; int bad;
        strobe(8'h96, 1'b0, 1'b0, 5'd5);
        sb.delete();
        repeat (16 * 4 + 5) @(negedge CLK_tx);
        n_total++;
        if ({bus.Busy_tx, bus.TX_OUT_tx} !== 2'b10)
            $display("FAIL pre_reset data bit3 busy/tx got %b%b want 10", bus.Busy_tx, bus.TX_OUT_tx);
        else n_pass++;
        RST_tx = 1'b1;
        @(posedge CLK_tx); #1;
        n_total++;
        if ({bus.TX_OUT_tx, bus.Busy_tx} !== 2'b10)
            $display("FAIL abort_edge tx/busy got %b%b want 10", bus.TX_OUT_tx, bus.Busy_tx);
        else n_pass++;
        repeat (2) @(negedge CLK_tx);
        RST_tx = 1'b0;
        bad = 0;
        repeat (10) begin
            @(negedge CLK_tx);
            if ({bus.TX_OUT_tx, bus.Busy_tx} !== 2'b10) bad++;
        end
        n_total++;
        if (bad !== 0) $display("FAIL post_reset_idle bad cycles got %0d want 0", bad);
        else n_pass++;
        strobe(8'h96, 1'b0, 1'b0, 5'd5);
        capture(started);
        e = sb.pop_front();
        errs = wave_errs(e);
        n_total++;
        if (cap.size() !== 160 || errs !== 0)
            $display("FAIL clean_frame_p5 len got %0d want 160, bad cycles %0d", cap.size(), errs);
        else n_pass++;
    endtask

    // An RX-style edge/bit counter runs over the captured line. Every transition must land on an edge-count wrap.
    task automatic test_loopback();
        exp_t e; bit started; int rx_edge; int rx_bit; int misalign; logic [DW:0] sh;
        logic [4:0] pres [2];
        logic [7:0] vals [3];
        pres[0] = 5'd8; pres[1] = 5'd16;
        vals[0] = 8'h00; vals[1] = 8'hFF; vals[2] = 8'h5A;
        for (int pi = 0; pi < 2; pi++) begin
            for (int vi = 0; vi < 3; vi++) begin
                strobe(vals[vi], 1'b0, 1'b0, pres[pi]);
                capture(started);
                e = sb.pop_front();
                rx_edge = 0; rx_bit = 0; misalign = 0; sh = '0;
                for (int i = 0; i < cap.size(); i++) begin
                    if (i > 0 && cap[i] !== cap[i-1] && rx_edge != 0) misalign++;
                    if (rx_edge == e.p / 2 && rx_bit >= 1 && rx_bit <= DW + 1)
                        sh[rx_bit-1] = cap[i];
                    rx_edge++;
                    if (rx_edge == e.p) begin
                        rx_edge = 0;
                        rx_bit++;
                    end
                end
                n_total++;
                if (rx_bit !== DW + 2 || rx_edge !== 0)
                    $display("FAIL loop_p%0d_%h bit/edge count got %0d/%0d want %0d/0", e.p, vals[vi], rx_bit, rx_edge, DW + 2);
                else n_pass++;
                n_total++;
                if (misalign !== 0)
                    $display("FAIL loop_p%0d_%h misaligned transitions got %0d want 0", e.p, vals[vi], misalign);
                else n_pass++;
                n_total++;
                if (sh !== {1'b1, vals[vi]})
                    $display("FAIL loop_p%0d_%h stop+data got %h want %h", e.p, vals[vi], sh, {1'b1, vals[vi]});
                else n_pass++;
            end
        end
    endtask

    initial begin
        test_reset();
        test_8n1();
        test_parity_and_ignore();
        test_back_to_back();
        test_reset_midframe();
        test_loopback();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation time limit reached, passed %0d of %0d", n_pass, n_total);
        $fatal(1);
    end
endmodule

// File: doc/uart_tx_frame_gen.md
Name: uart_tx_frame_gen

Overview:
UART transmitter: the TX end of the link whose RX side uses prescale-8/16 edge/bit counting. It accepts one parallel byte on a valid strobe and serializes it as start, data LSB-first, optional parity and stop. Each bit lasts exactly Prescale clocks of the same oversampling clock that drives the RX counters. An internal edge/bit counter pair mirrors the RX counter's timing.

Parameters:
DATA_WIDTH, 8, number of data bits per frame (bit counter sized ceil(log2(DATA_WIDTH)))

Ports:
CLK_tx  input  1  oversampling clock, single clock domain
RST_tx  input  1  synchronous, active-high reset
Prescale_tx  input  5  clocks per bit; 8 or 16
P_DATA_tx  input  DATA_WIDTH  parallel data to send
Data_Valid_tx  input  1  request strobe; one-cycle pulse or level
PAR_EN_tx  input  1  1 = insert parity bit
PAR_TYP_tx  input  1  0 = even, 1 = odd parity
TX_OUT_tx  output  1  serial line, registered, idle high
Busy_tx  output  1  registered; high while a frame is in progress

Behaviour:
- Clock/reset: one clock (CLK_tx), reset synchronous and active-high (RST_tx); all state updates on posedge CLK_tx only.
- Reset values: TX_OUT_tx=1, Busy_tx=0, state=IDLE, edge_cnt=0, bit_cnt=0, data/parity/config latches=0.
- Reset mid-frame: frame aborted at that edge; TX_OUT_tx=1 and Busy_tx=0 from that edge; no partial bits resume.
- States: IDLE -> START -> DATA -> PARITY (only if latched PAR_EN=1) -> STOP -> IDLE.
- Acceptance: in IDLE, edge sampling Data_Valid_tx=1 latches P_DATA_tx, PAR_EN_tx, PAR_TYP_tx and Prescale_tx. At that same edge, state moves to START, TX_OUT_tx goes 0 and Busy_tx goes 1.
- Data_Valid_tx while Busy_tx=1 is ignored; no queueing.
- Inputs changing mid-frame have no effect. Prescale is used only as latched.
- Prescale decode: 8 -> 8 clocks/bit; 16 -> 16; any other value -> 16.
- Edge counter: 0 .. P-1, increments each clock in START/DATA/PARITY/STOP. At P-1 it wraps to 0 and the next bit is driven on that edge, so every bit is exactly P cycles.
- DATA: bit_cnt 0..DATA_WIDTH-1; TX_OUT_tx = data[bit_cnt], LSB first. At end of bit DATA_WIDTH-1, go to PARITY or STOP; bit_cnt returns to 0.
- Parity: even = XOR of latched data; odd = its inverse. Computed from latched data only.
- STOP: TX_OUT_tx=1 for P cycles. At the edge ending the stop bit, state=IDLE and Busy_tx=0; TX_OUT_tx stays 1.
- Back-to-back frames: earliest new acceptance is the first edge with Busy_tx=0. This gives at least one idle-high cycle between frames.
- Frame length: (DATA_WIDTH+2+PAR_EN)*P cycles with Busy_tx high, e.g. 8N1@P=8 -> 80 cycles; 8E1@P=16 -> 176 cycles.
- No combinational path from any input to any output.

Test Plan:
- Reset, then idle 20 cycles -> TX_OUT_tx=1, Busy_tx=0 throughout.
- P=8, PAR_EN=0, data 0xA5, 1-cycle strobe -> line 0 | 1,0,1,0,0,1,0,1 | 1, each bit 8 cycles; Busy_tx high exactly 80 cycles.
- P=16, PAR_EN=1, PAR_TYP=0, data 0x07 -> parity bit 1 (three ones); PAR_TYP=1 with same data -> parity 0. Frame 176 cycles.
- Strobe again mid-frame with 0xFF and change Prescale_tx to 8 -> ignored; frame timing and data unchanged. Strobe held high -> next frame starts one cycle after Busy_tx falls.
- Prescale_tx=5 -> 16-cycle bits. Assert RST_tx during bit 3 of a frame -> TX_OUT_tx=1, Busy_tx=0 at that edge; a new strobe after release sends a clean full frame.
- Loopback into the existing RX edge/bit counter path at P=8 and P=16 -> RX bit/edge counts align with TX bit boundaries for 0x00, 0xFF, 0x5A.
